cam_cfg_seq: RTL and testbench

// - Upstream companion of the SCCB write controller (sccb_ctrl): powers up the camera, then feeds sccb_ctrl.
// - Sequences cam_pwdn/cam_rst_n, holds sccb_ctrl in reset until the camera is stable, then releases it.
// - Serves wire_data {ID,addr,data} from an internal register table indexed by sccb_ctrl's reg_order.
// - Watchdogs config_done, retries via camera + SCCB re-reset, and reports ready/error.

---
 rtl/cam_cfg_seq.sv | 123 ++++++++++++
 tb/tb_cam_cfg_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cam_cfg_seq.sv
// cam_cfg_seq: camera power-up sequencer, sccb_ctrl reset/watchdog and register table source
module cam_cfg_seq #(
  parameter logic [7:0]  SLAVE_ID    = 8'h42,
  parameter int unsigned REG_NUM     = 179,
  parameter int unsigned PWDN_NUM    = 10000,
  parameter int unsigned RST_NUM     = 10000,
  parameter int unsigned SETTLE_NUM  = 10000,
  parameter int unsigned TIMEOUT_NUM = 6000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk_10MHz,
  input  logic        rst_n,
  input  logic        cfg_restart,
  input  logic [7:0]  reg_order,
  input  logic        config_done,
  output logic [23:0] wire_data,
  output logic        sccb_rst_n,
  output logic        cam_pwdn,
  output logic        cam_rst_n,
  output logic        cfg_ready,
  output logic        cfg_error,
  output logic [1:0]  retry_cnt
);
  typedef enum logic [2:0] {S_PWDN, S_RESET, S_SETTLE, S_CONFIG, S_RETRY, S_DONE, S_ERROR} state_t;
  localparam logic [22:0] PWDN_END    = 23'(PWDN_NUM - 1);
  localparam logic [22:0] RST_END     = 23'(RST_NUM - 1);
  localparam logic [22:0] SETTLE_END  = 23'(SETTLE_NUM - 1);
  localparam logic [22:0] TIMEOUT_END = 23'(TIMEOUT_NUM - 1);
  localparam logic [22:0] RETRY_END   = 23'd15;
  localparam logic [1:0]  MAX_R       = 2'(MAX_RETRY);
  state_t      state, state_d;
  logic [22:0] cnt;
  logic        done_q;
  logic [1:0]  retry_d;
  // Register contents behind each index; index 0 soft-resets the sensor first.
  // Unlisted indices carry the 0xFF/0xF0 delay marker so sccb_ctrl always has REG_NUM writes.
  function automatic logic [15:0] cfg_entry(input logic [7:0] idx);
    case (idx)
      8'd0:  cfg_entry = 16'h1280;
      8'd1:  cfg_entry = 16'h1180;
      8'd2:  cfg_entry = 16'h1214;
      8'd3:  cfg_entry = 16'h0C04;
      8'd4:  cfg_entry = 16'h3E19;
      8'd5:  cfg_entry = 16'h40D0;
      8'd6:  cfg_entry = 16'h8C00;
      8'd7:  cfg_entry = 16'h3A04;
      8'd8:  cfg_entry = 16'h1418;
      8'd9:  cfg_entry = 16'h4FB3;
      8'd10: cfg_entry = 16'h50B3;
      8'd11: cfg_entry = 16'h5100;
      8'd12: cfg_entry = 16'h523D;
      8'd13: cfg_entry = 16'h53A7;
      8'd14: cfg_entry = 16'h54E4;
      8'd15: cfg_entry = 16'h589E;
      8'd16: cfg_entry = 16'h3DC0;
      8'd17: cfg_entry = 16'h1714;
      8'd18: cfg_entry = 16'h1802;
      8'd19: cfg_entry = 16'h3280;
      8'd20: cfg_entry = 16'h1903;
      8'd21: cfg_entry = 16'h1A7B;
      8'd22: cfg_entry = 16'h030A;
      8'd23: cfg_entry = 16'h703A;
      8'd24: cfg_entry = 16'h7135;
      8'd25: cfg_entry = 16'h7211;
      8'd26: cfg_entry = 16'h73F1;
      8'd27: cfg_entry = 16'hA202;
      8'd28: cfg_entry = 16'h1500;
      8'd29: cfg_entry = 16'h13E7;
      8'd30: cfg_entry = 16'h1E07;
      default: cfg_entry = 16'hFFF0;
    endcase
  endfunction
  // Next state and retry bookkeeping; pin levels are decoded from the next state so they change with it.
  always_comb begin
    state_d = state;
    retry_d = retry_cnt;
    case (state)
      S_PWDN:   state_d = (cnt == PWDN_END) ? S_RESET : S_PWDN;
      S_RESET:  state_d = (cnt == RST_END) ? S_SETTLE : S_RESET;
      S_SETTLE: state_d = (cnt == SETTLE_END) ? S_CONFIG : S_SETTLE;
      S_CONFIG: state_d = (cnt == TIMEOUT_END) ? ((retry_cnt == MAX_R) ? S_ERROR : S_RETRY)
                        : (done_q && cnt >= 23'd2) ? S_DONE : S_CONFIG;
      S_RETRY: begin
        state_d = (cnt == RETRY_END) ? S_RESET : S_RETRY;
        retry_d = (cnt == RETRY_END && retry_cnt != MAX_R) ? retry_cnt + 2'd1 : retry_cnt;
      end
      S_DONE, S_ERROR: begin
        state_d = cfg_restart ? S_PWDN : state;
        retry_d = cfg_restart ? 2'd0 : retry_cnt;
      end
      default: state_d = S_PWDN;
    endcase
  end
  // State, counter, registered pins and status flags.
  always_ff @(posedge clk_10MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWDN;
      cnt        <= '0;
      done_q     <= 1'b0;
      retry_cnt  <= '0;
      cam_pwdn   <= 1'b1;
      cam_rst_n  <= 1'b0;
      sccb_rst_n <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_error  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= (state_d != state) ? '0 : cnt + 23'd1;
      done_q     <= config_done;
      retry_cnt  <= retry_d;
      cam_pwdn   <= state_d == S_PWDN;
      cam_rst_n  <= !(state_d inside {S_PWDN, S_RESET, S_RETRY});
      sccb_rst_n <= state_d inside {S_CONFIG, S_DONE};
      cfg_ready  <= state_d == S_DONE;
      cfg_error  <= state_d == S_ERROR;
    end
  end
  // Table lookup, one cycle behind reg_order, independent of the sequencer state.
  always_ff @(posedge clk_10MHz or negedge rst_n) begin
    if (!rst_n) wire_data <= '0;
    else wire_data <= (32'(reg_order) >= REG_NUM) ? {SLAVE_ID, 16'hFFFF} : {SLAVE_ID, cfg_entry(reg_order)};
  end
endmodule

// File: tb/tb_cam_cfg_seq.sv
// tb_cam_cfg_seq: self-checking bench for cam_cfg_seq with shortened timings
module tb_cam_cfg_seq;
  logic        clk_10MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_restart = 1'b0;
  logic [7:0]  reg_order = 8'd5;
  logic        config_done = 1'b0;
  logic [23:0] wire_data;
  logic        sccb_rst_n, cam_pwdn, cam_rst_n, cfg_ready, cfg_error;
  logic [1:0]  retry_cnt;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  cam_cfg_seq #(
    .SLAVE_ID(8'h42), .REG_NUM(179), .PWDN_NUM(8), .RST_NUM(8),
    .SETTLE_NUM(8), .TIMEOUT_NUM(200), .MAX_RETRY(3)
  ) dut (
    .clk_10MHz(clk_10MHz), .rst_n(rst_n), .cfg_restart(cfg_restart),
    .reg_order(reg_order), .config_done(config_done), .wire_data(wire_data),
    .sccb_rst_n(sccb_rst_n), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .cfg_ready(cfg_ready), .cfg_error(cfg_error), .retry_cnt(retry_cnt)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_10MHz);
    #1;
  endtask

  task automatic tbl(input logic [7:0] idx, input logic [23:0] exp);
    reg_order = idx;
    exp_q.push_back({8'h00, exp});
    tick();
    chk("tbl", {8'h00, wire_data}, exp_q.pop_front());
  endtask

  initial begin
    logic prev_cr, prev_sc;
    int lo, hi, sl, falls, runs;
    repeat (3) tick();
    chk("rst_pwdn", cam_pwdn, 1);
    chk("rst_cam_rst_n", cam_rst_n, 0);
    chk("rst_sccb", sccb_rst_n, 0);
    chk("rst_wire", wire_data, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_retry", retry_cnt, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 7)  chk("pwdn_hi_7", cam_pwdn, 1);
      if (i == 8)  chk("pwdn_lo_8", cam_pwdn, 0);
      if (i == 15) chk("camrst_lo_15", cam_rst_n, 0);
      if (i == 16) chk("camrst_hi_16", cam_rst_n, 1);
      if (i == 23) chk("sccb_lo_23", sccb_rst_n, 0);
      if (i == 24) chk("sccb_hi_24", sccb_rst_n, 1);
      if (i == 24) chk("ready_lo_24", cfg_ready, 0);
    end
    tbl(8'd0, 24'h421280);
    tbl(8'd200, 24'h42FFFF);
    tbl(8'd179, 24'h42FFFF);
    tbl(8'd255, 24'h42FFFF);
    tbl(8'd0, 24'h421280);
    repeat (45) tick();
    chk("sccb_hi_cnt50", sccb_rst_n, 1);
    config_done = 1'b1;
    tick();
    chk("ready_after1", cfg_ready, 0);
    tick();
    chk("ready_after2", cfg_ready, 1);
    chk("retry_done", retry_cnt, 0);
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    chk("restart_ready_clr", cfg_ready, 0);
    chk("restart_pwdn", cam_pwdn, 1);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 16) cfg_restart = 1'b1;
      if (i == 17) begin
        cfg_restart = 1'b0;
        chk("settle_restart_ign", cam_pwdn, 0);
      end
      if (i == 24) chk("stale_sccb_hi", sccb_rst_n, 1);
      if (i == 24) chk("stale_ready_0", cfg_ready, 0);
    end
    tick();
    chk("stale_ready_1", cfg_ready, 0);
    tick();
    chk("stale_ready_2", cfg_ready, 0);
    tick();
    chk("stale_ready_3", cfg_ready, 1);
    config_done = 1'b0;
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    prev_cr = cam_rst_n;
    prev_sc = sccb_rst_n;
    lo = 0; hi = 0; sl = 0; falls = 0; runs = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (prev_cr && !cam_rst_n) begin
        falls++;
        exp_q.push_back(32'd24);
        lo = 0;
      end
      if (!cam_rst_n) lo++;
      if (!prev_cr && cam_rst_n && exp_q.size() > 0) chk("camrst_low_len", lo, exp_q.pop_front());
      if (sccb_rst_n) begin
        if (!prev_sc && runs > 0) chk("sccb_low_len", sl, 32);
        hi++;
        sl = 0;
      end else begin
        if (prev_sc) begin
          runs++;
          chk("cfg_window", hi, 200);
        end
        hi = 0;
        sl++;
      end
      prev_cr = cam_rst_n;
      prev_sc = sccb_rst_n;
      if (cfg_error) break;
    end
    chk("err_flag", cfg_error, 1);
    chk("err_retry", retry_cnt, 3);
    chk("err_retry_visits", falls, 3);
    chk("err_cfg_windows", runs, 4);
    chk("err_ready", cfg_ready, 0);
    chk("err_sccb", sccb_rst_n, 0);
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    chk("err_restart_error", cfg_error, 0);
    chk("err_restart_retry", retry_cnt, 0);
    chk("err_restart_pwdn", cam_pwdn, 1);
    repeat (12) tick();
    reg_order = 8'd0;
    tick();
    chk("mid_wire", wire_data, 24'h421280);
    chk("mid_pwdn", cam_pwdn, 0);
    #20;
    rst_n = 1'b0;
    #1;
    chk("async_wire", wire_data, 0);
    chk("async_pwdn", cam_pwdn, 1);
    chk("async_camrst", cam_rst_n, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
